i2c_target_regfile: RTL and testbench

//  I2C target (slave) with an NREG x 8 register file, attached to the i2c_scl/i2c_sda open-drain bus driven by i2c_top.

---
 rtl/i2c_target_regfile.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with an NREG x 8 register file, local read port and write strobes
module i2c_target_regfile #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         NREG     = 16,
    parameter int         FILT_LEN = 3,
    localparam int        PW       = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [PW-1:0] host_addr,
    output logic [7:0]    host_rdata,
    output logic          wr_evt,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // Bit 1 carries SCL, bit 0 carries SDA through the sync/filter pipeline.
    logic [1:0]      sync1_q, sync2_q, filt_q, prev_q;
    logic [1:0][2:0] cnt_q;

    state_t          state_q;
    logic [3:0]      bitcnt_q;
    logic [7:0]      shift_q;
    logic [7:0]      tx_q;
    logic            ack_q;
    logic            rw_q;
    logic [PW-1:0]   ptr_q;
    logic [7:0]      regs_q [NREG];

    logic            scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]      shift_d;
    logic [PW-1:0]   ptr_d;

    assign scl_rise   = filt_q[1] & ~prev_q[1];
    assign scl_fall   = ~filt_q[1] & prev_q[1];
    assign start_det  = filt_q[1] & prev_q[1] & prev_q[0] & ~filt_q[0];
    assign stop_det   = filt_q[1] & prev_q[1] & ~prev_q[0] & filt_q[0];
    assign shift_d    = {shift_q[6:0], filt_q[0]};
    assign ptr_d      = ptr_q + PW'(1);
    assign host_rdata = regs_q[host_addr];

    // Two-flop synchronizers, then a level only moves after FILT_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            prev_q  <= 2'b11;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {scl_i, sda_i};
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == 3'(FILT_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 3'd1;
                end
            end
        end
    end

    // Protocol FSM: shifts bits on SCL rise, changes SDA drive only after SCL fall; START/STOP win over all states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            tx_q     <= '0;
            ack_q    <= 1'b0;
            rw_q     <= 1'b0;
            ptr_q    <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_evt   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
        end else begin
            wr_evt <= 1'b0;
            if (stop_det) begin
                state_q <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (start_det) begin
                state_q  <= ADDR;
                bitcnt_q <= '0;
                sda_oe   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shift_q  <= shift_d;
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end else if (scl_fall && bitcnt_q == 4'd8) begin
                            if (shift_q[7:1] == SLV_ADDR) begin
                                state_q <= ADDR_ACK;
                                rw_q    <= shift_q[0];
                                sda_oe  <= 1'b1;
                                busy    <= 1'b1;
                            end else begin
                                state_q <= IGNORE;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bitcnt_q <= '0;
                            if (rw_q) begin
                                state_q <= RDATA;
                                tx_q    <= regs_q[ptr_q];
                                sda_oe  <= ~regs_q[ptr_q][7];
                            end else begin
                                state_q <= PTR;
                                sda_oe  <= 1'b0;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            shift_q  <= shift_d;
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end else if (scl_fall && bitcnt_q == 4'd8) begin
                            ptr_q   <= shift_q[PW-1:0];
                            sda_oe  <= 1'b1;
                            state_q <= PTR_ACK;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe   <= 1'b0;
                            bitcnt_q <= '0;
                            state_q  <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shift_q  <= shift_d;
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd7) begin
                                regs_q[ptr_q] <= shift_d;
                                wr_evt        <= 1'b1;
                                wr_addr       <= ptr_q;
                                wr_data       <= shift_d;
                                ptr_q         <= ptr_d;
                            end
                        end else if (scl_fall && bitcnt_q == 4'd8) begin
                            sda_oe  <= 1'b1;
                            state_q <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bitcnt_q == 4'd8) begin
                                sda_oe  <= 1'b0;
                                ptr_q   <= ptr_d;
                                state_q <= RDATA_ACK;
                            end else begin
                                tx_q   <= {tx_q[6:0], 1'b0};
                                sda_oe <= ~tx_q[6];
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            ack_q <= ~filt_q[0];
                        end else if (scl_fall) begin
                            if (ack_q) begin
                                state_q  <= RDATA;
                                bitcnt_q <= '0;
                                tx_q     <= regs_q[ptr_q];
                                sda_oe   <= ~regs_q[ptr_q][7];
                            end else begin
                                state_q <= IGNORE;
                            end
                        end
                    end
                    IGNORE: sda_oe <= 1'b0;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - scoreboard bench for i2c_target_regfile with a bit-level bus controller
module tb_i2c_target_regfile;

    localparam int PW = 4;
    localparam int Q  = 20;

    typedef struct {
        logic [PW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    typedef struct {
        int         id;
        logic [7:0] v;
    } rx_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scl_ctl = 1'b1;
    logic          sda_low = 1'b0;
    logic [PW-1:0] host_addr = '0;
    logic          sda_oe, wr_evt, busy;
    logic [7:0]    host_rdata, wr_data;
    logic [PW-1:0] wr_addr;
    logic          sda_bus;

    assign sda_bus = ~(sda_low | sda_oe);

    always #5 clk = ~clk;

    i2c_target_regfile #(.SLV_ADDR(7'h50), .NREG(16), .FILT_LEN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_ctl),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .host_addr (host_addr),
        .host_rdata(host_rdata),
        .wr_evt    (wr_evt),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         rx_id = 0;
    bit         oe_seen = 1'b0;
    wr_t        exp_wr[$];
    rx_t        exp_rx[$];
    logic [7:0] obs_rx[$];
    wr_t        mon_w;
    rx_t        mon_r;
    logic [7:0] mon_o;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes on each wr_evt and expected bus responses as the controller observes them.
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (wr_evt) begin
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_wr_evt: got addr %0h data %0h expected none", wr_addr, wr_data);
            end else begin
                mon_w = exp_wr.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_w.a));
                check("wr_data", 32'(wr_data), 32'(mon_w.d));
            end
        end
        while (obs_rx.size() > 0) begin
            mon_o = obs_rx.pop_front();
            if (exp_rx.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_bus_resp: got %0h expected none", mon_o);
            end else begin
                mon_r = exp_rx.pop_front();
                check($sformatf("bus_resp#%0d", mon_r.id), 32'(mon_o), 32'(mon_r.v));
            end
        end
    end

    task automatic q(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_low = 1'b0; q(Q);
        scl_ctl = 1'b1; q(Q);
        sda_low = 1'b1; q(Q);
        scl_ctl = 1'b0; q(Q);
    endtask

    task automatic bus_stop();
        sda_low = 1'b1; q(Q);
        scl_ctl = 1'b1; q(Q);
        sda_low = 1'b0; q(Q);
    endtask

    task automatic send_bit(input bit b, input bit g);
        sda_low = ~b;
        if (g) begin
            q(5); scl_ctl = 1'b1; q(2); scl_ctl = 1'b0; q(Q - 7);
        end else begin
            q(Q);
        end
        scl_ctl = 1'b1;
        if (g) begin
            q(8); sda_low = ~sda_low; q(2); sda_low = ~sda_low; q(2 * Q - 10);
        end else begin
            q(2 * Q);
        end
        scl_ctl = 1'b0; q(Q);
    endtask

    task automatic recv_bit(output bit b);
        sda_low = 1'b0; q(Q);
        scl_ctl = 1'b1; q(Q);
        b = sda_bus;    q(Q);
        scl_ctl = 1'b0; q(Q);
    endtask

    task automatic tx_byte(input logic [7:0] v, input bit exp_nack, input bit g);
        rx_t e;
        bit  a;
        e.id = rx_id++;
        e.v  = {7'b0, exp_nack};
        exp_rx.push_back(e);
        for (int i = 7; i >= 0; i--) send_bit(v[i], g);
        recv_bit(a);
        obs_rx.push_back({7'b0, a});
    endtask

    task automatic rx_byte(input logic [7:0] exp, input bit nack);
        rx_t        e;
        logic [7:0] d;
        bit         b;
        e.id = rx_id++;
        e.v  = exp;
        exp_rx.push_back(e);
        d = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
        send_bit(nack, 1'b0);
        obs_rx.push_back(d);
    endtask

    task automatic exp_write(input logic [PW-1:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
    endtask

    task automatic host_chk(input string name, input logic [PW-1:0] a, input logic [7:0] exp);
        host_addr = a;
        #1;
        check(name, 32'(host_rdata), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish within 1 ms");
        $fatal(1);
    end

    initial begin
        bit b;
        q(4);
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_wr_evt", 32'(wr_evt), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        q(8);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        host_chk("rst_reg0", 0, 8'h00);
        host_chk("rst_reg15", 15, 8'h00);

        // Preload reg5/reg6 so later pointer checks read distinctive data.
        bus_start(); tx_byte(8'hA0, 0, 0); tx_byte(8'h05, 0, 0);
        exp_write(5, 8'hC3); tx_byte(8'hC3, 0, 0);
        exp_write(6, 8'h3C); tx_byte(8'h3C, 0, 0);
        bus_stop();

        // Test 1: pointer 3, two data bytes.
        bus_start(); tx_byte(8'hA0, 0, 0);
        check("t1_busy_after_addr", 32'(busy), 1);
        tx_byte(8'h03, 0, 0);
        exp_write(3, 8'hA5); tx_byte(8'hA5, 0, 0);
        exp_write(4, 8'h5A); tx_byte(8'h5A, 0, 0);
        bus_stop();
        host_chk("t1_reg4", 4, 8'h5A);
        host_chk("t1_reg3", 3, 8'hA5);

        // Test 2: write pointer, repeated START, read two bytes.
        bus_start(); tx_byte(8'hA0, 0, 0); tx_byte(8'h03, 0, 0);
        bus_start(); tx_byte(8'hA1, 0, 0);
        rx_byte(8'hA5, 0); rx_byte(8'h5A, 1);
        bus_stop();
        q(5);
        check("t2_busy_after_stop", 32'(busy), 0);
        bus_start(); tx_byte(8'hA1, 0, 0); rx_byte(8'hC3, 1); bus_stop();

        // Test 3: foreign address is ignored; pointer stays at 6.
        oe_seen = 1'b0;
        bus_start(); tx_byte(8'hA2, 1, 0); tx_byte(8'h00, 1, 0); tx_byte(8'h99, 1, 0); bus_stop();
        check("t3_sda_oe_never", 32'(oe_seen), 0);
        check("t3_busy", 32'(busy), 0);
        bus_start(); tx_byte(8'hA1, 0, 0); rx_byte(8'h3C, 1); bus_stop();

        // Test 4: pointer wrap and upper pointer bits dropped.
        bus_start(); tx_byte(8'hA0, 0, 0); tx_byte(8'h0F, 0, 0);
        exp_write(15, 8'h11); tx_byte(8'h11, 0, 0);
        exp_write(0, 8'h22);  tx_byte(8'h22, 0, 0);
        bus_stop();
        host_chk("t4_reg15", 15, 8'h11);
        host_chk("t4_reg0", 0, 8'h22);
        bus_start(); tx_byte(8'hA1, 0, 0); rx_byte(8'h00, 1); bus_stop();
        bus_start(); tx_byte(8'hA0, 0, 0); tx_byte(8'h13, 0, 0); bus_stop();
        bus_start(); tx_byte(8'hA1, 0, 0); rx_byte(8'hA5, 1); bus_stop();

        // Test 5: short glitches while idle and inside every transmitted bit.
        q(10);
        scl_ctl = 1'b0; q(2); scl_ctl = 1'b1; q(10);
        sda_low = 1'b1; q(2); sda_low = 1'b0; q(10);
        check("t5_idle_busy", 32'(busy), 0);
        bus_start(); tx_byte(8'hA0, 0, 1); tx_byte(8'h08, 0, 1);
        exp_write(8, 8'h96); tx_byte(8'h96, 0, 1);
        bus_stop();
        host_chk("t5_reg8", 8, 8'h96);

        // Test 6: reset while the target is pulling SDA low during a read.
        bus_start(); tx_byte(8'hA0, 0, 0); tx_byte(8'h03, 0, 0);
        bus_start(); tx_byte(8'hA1, 0, 0);
        for (int i = 0; i < 8 && !sda_oe; i++) recv_bit(b);
        check("t6_oe_driving", 32'(sda_oe), 1);
        rst = 1'b1;
        q(1);
        check("t6_oe_released", 32'(sda_oe), 0);
        check("t6_busy", 32'(busy), 0);
        host_chk("t6_reg3_cleared", 3, 8'h00);
        host_chk("t6_reg5_cleared", 5, 8'h00);
        rst = 1'b0;
        q(10);
        bus_stop();
        bus_start(); tx_byte(8'hA0, 0, 0); tx_byte(8'h02, 0, 0);
        exp_write(2, 8'h5C); tx_byte(8'h5C, 0, 0);
        bus_stop();
        host_chk("t6_reg2", 2, 8'h5C);

        q(50);
        check("exp_wr_drained", 32'(exp_wr.size()), 0);
        check("exp_rx_drained", 32'(exp_rx.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
